// File: rtl/calc_pkg.sv
// Shared definitions for the calculator blocks: FSM state encoding and a
// constant-time ceil(log2) helper used to size counters.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } calc_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/divmod_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module divmod_step #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] rem,
    input  logic            bit_in,
    input  logic [BITS-1:0] divisor,
    output logic [BITS-1:0] rem_next,
    output logic            q_bit
);

    logic [BITS:0] shifted;
    logic [BITS:0] diff;

    // rem < divisor holds between steps, so the top bit of the BITS+1 wide
    // difference is exactly the borrow of the trial subtraction.
    always_comb begin
        shifted  = {rem, bit_in};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[BITS];
        rem_next = q_bit ? diff[BITS-1:0] : shifted[BITS-1:0];
    end

endmodule

// File: rtl/divmod.sv
// Iterative signed/unsigned divider: one quotient bit per clock, results
// registered and published only when an operation completes.
module divmod
    import calc_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [BITS-1:0] n,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q,
    output logic [BITS-1:0] r,
    output logic            rdy,
    output logic            busy,
    output logic            div_zero
);

    localparam int unsigned CW = (clog2(BITS) < 1) ? 1 : clog2(BITS);

    calc_state_t     state, state_next;
    logic [CW-1:0]   cnt;

    logic [BITS-1:0] n_raw, d_raw;
    logic            sgn_raw;
    logic [BITS-1:0] dvd, pr, dm;
    logic            q_neg, r_neg, dz_lat;
    logic [BITS-1:0] rem_next;
    logic            q_bit;

    divmod_step #(.BITS(BITS)) u_step (
        .rem      (pr),
        .bit_in   (dvd[BITS-1]),
        .divisor  (dm),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_PREP;
        end else begin
            unique case (state)
                ST_IDLE: state_next = ST_IDLE;
                ST_PREP: state_next = ST_RUN;
                ST_RUN:  if (cnt == '0) state_next = ST_FIX;
                ST_FIX:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            rdy      <= 1'b0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            rdy  <= 1'b0;
            busy <= 1'b1;
        end else begin
            unique case (state)
                ST_PREP: cnt <= CW'(BITS - 1);
                ST_RUN:  cnt <= cnt - 1'b1;
                ST_FIX: begin
                    q        <= dz_lat ? '1 : (q_neg ? -dvd : dvd);
                    r        <= dz_lat ? n_raw : (r_neg ? -pr : pr);
                    div_zero <= dz_lat;
                    rdy      <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Working registers are never visible at the outputs before FIX, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            n_raw   <= n;
            d_raw   <= d;
            sgn_raw <= is_signed;
        end else if (state == ST_PREP) begin
            dvd    <= (sgn_raw && n_raw[BITS-1]) ? -n_raw : n_raw;
            dm     <= (sgn_raw && d_raw[BITS-1]) ? -d_raw : d_raw;
            pr     <= '0;
            q_neg  <= sgn_raw && (n_raw[BITS-1] ^ d_raw[BITS-1]);
            r_neg  <= sgn_raw && n_raw[BITS-1];
            dz_lat <= (d_raw == '0);
        end else if (state == ST_RUN) begin
            dvd <= {dvd[BITS-2:0], q_bit};
            pr  <= rem_next;
        end
    end

endmodule

// File: tb/tb_divmod.sv
// Directed bench for divmod: 8-bit result/latency vectors, 32-bit restart
// behaviour and asynchronous reset.
module tb_divmod;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  n8 = '0, d8 = '0, q8, r8;
    logic        rdy8, busy8, dz8;

    logic        start32 = 1'b0, sgn32 = 1'b0;
    logic [31:0] n32 = '0, d32 = '0, q32, r32;
    logic        rdy32, busy32, dz32;

    int checks = 0;
    int failures = 0;
    logic [7:0] prev_q8 = '0;

    always #5 clk = ~clk;

    divmod #(.BITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
        .n(n8), .d(d8), .q(q8), .r(r8), .rdy(rdy8), .busy(busy8), .div_zero(dz8)
    );

    divmod #(.BITS(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(sgn32),
        .n(n32), .d(d32), .q(q32), .r(r32), .rdy(rdy32), .busy(busy32), .div_zero(dz32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one 8-bit division and checks exact latency, hold of the previous
    // result while running, and the final outputs.
    task automatic div8(input string tag, input logic s, input logic [7:0] nv, input logic [7:0] dv,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
        @(negedge clk);
        start8 = 1'b1; sgn8 = s; n8 = nv; d8 = dv;
        @(posedge clk); #1;
        start8 = 1'b0; n8 = 8'hA5; d8 = 8'h3C; sgn8 = ~s;
        check({tag, " busy@E"}, 64'(busy8), 64'd1);
        check({tag, " rdy@E"}, 64'(rdy8), 64'd0);
        repeat (9) @(posedge clk);
        #1;
        check({tag, " rdy@E+9"}, 64'(rdy8), 64'd0);
        check({tag, " qhold"}, 64'(q8), 64'(prev_q8));
        @(posedge clk); #1;
        check({tag, " rdy@E+10"}, 64'(rdy8), 64'd1);
        check({tag, " busy@E+10"}, 64'(busy8), 64'd0);
        check({tag, " q"}, 64'(q8), 64'(eq));
        check({tag, " r"}, 64'(r8), 64'(er));
        check({tag, " dz"}, 64'(dz8), 64'(edz));
        prev_q8 = eq;
    endtask

    initial begin
        int rises;
        int first_rise;
        logic last_rdy;

        #12;
        check("reset q", 64'(q8), 64'd0);
        check("reset rdy", 64'(rdy8), 64'd0);
        check("reset busy", 64'(busy8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        div8("u200/7",  1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0);
        div8("s-7/2",   1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0);
        div8("s7/-2",   1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0);
        div8("sMIN/-1", 1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0);
        div8("u80/FF",  1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0);
        div8("u5A/0",   1'b0, 8'h5A,  8'h00,  8'hFF,  8'h5A,  1'b1);
        div8("s5A/0",   1'b1, 8'h5A,  8'h00,  8'hFF,  8'h5A,  1'b1);
        div8("uFF/1",   1'b0, 8'hFF,  8'h01,  8'hFF,  8'h00,  1'b0);
        div8("s-128/7", 1'b1, 8'h80,  8'h07,  8'hEE,  8'hFE,  1'b0);

        // 32-bit: restart 5 cycles into an operation
        @(negedge clk);
        start32 = 1'b1; sgn32 = 1'b0; n32 = 32'd100; d32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start32 = 1'b1; n32 = 32'd1000; d32 = 32'd10;
        @(posedge clk); #1;
        start32 = 1'b0; n32 = '0; d32 = '0;
        check("restart busy", 64'(busy32), 64'd1);
        check("restart rdy", 64'(rdy32), 64'd0);
        rises = 0; first_rise = -1; last_rdy = rdy32;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (rdy32 && !last_rdy) begin
                rises++;
                if (first_rise < 0) first_rise = k;
            end
            last_rdy = rdy32;
        end
        check("restart rise cycle", 64'(first_rise), 64'd34);
        check("restart rise count", 64'(rises), 64'd1);
        check("restart q", 64'(q32), 64'd100);
        check("restart r", 64'(r32), 64'd0);
        check("restart dz", 64'(dz32), 64'd0);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; n8 = 8'd100; d8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async q", 64'(q8), 64'd0);
        check("async r", 64'(r8), 64'd0);
        check("async rdy", 64'(rdy8), 64'd0);
        check("async busy", 64'(busy8), 64'd0);
        check("async dz", 64'(dz8), 64'd0);
        check("async q32", 64'(q32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_q8 = '0;
        repeat (12) @(posedge clk);
        #1;
        check("post-reset no rdy", 64'(rdy8), 64'd0);
        div8("u50/5", 1'b0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1);
    end

endmodule
